// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the imem req/ack handshake and
// writes {pc, inst} pairs into the IF/ID register, honouring stall and redirect.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_INST = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     inst_o,
  output logic            valid_o,
  output logic            flush_o
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DRAIN
  } state_e;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic [31:0]     buf_q, buf_d;
  logic [XLEN-1:0] pc_out_q, pc_out_d;
  logic [31:0]     inst_q, inst_d;
  logic            valid_q, valid_d;
  logic            flush_q, flush_d;

  logic [XLEN-1:0] redirect_tgt;
  assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};

  // In DRAIN pc_q still holds the abandoned request address; the redirect
  // target waits in tgt_q so imem_addr stays stable until the late ack.
  assign imem_req  = (state_q == FETCH) || (state_q == DRAIN);
  assign imem_addr = pc_q;

  assign pc_o    = pc_out_q;
  assign inst_o  = inst_q;
  assign valid_o = valid_q;
  assign flush_o = flush_q;

  always_comb begin
    // NOTE: every next-state variable gets a default first so no path through
    // the case statement leaves one unassigned and infers a latch.
    state_d  = state_q;
    pc_d     = pc_q;
    tgt_d    = tgt_q;
    buf_d    = buf_q;
    pc_out_d = pc_out_q;
    inst_d   = inst_q;
    valid_d  = 1'b0;
    flush_d  = 1'b0;

    if (redirect) begin
      flush_d = 1'b1;
      inst_d  = NOP_INST;
    end

    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (redirect) pc_d = redirect_tgt;
      end

      FETCH: begin
        if (redirect) begin
          if (imem_ack) begin
            pc_d = redirect_tgt;
          end else begin
            tgt_d   = redirect_tgt;
            state_d = DRAIN;
          end
        end else if (imem_ack) begin
          if (stall) begin
            buf_d   = imem_rdata;
            state_d = HOLD;
          end else begin
            pc_out_d = pc_q;
            inst_d   = imem_rdata;
            valid_d  = 1'b1;
            pc_d     = pc_q + PC_STEP;
          end
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_d    = redirect_tgt;
          state_d = FETCH;
        end else if (!stall) begin
          pc_out_d = pc_q;
          inst_d   = buf_q;
          valid_d  = 1'b1;
          pc_d     = pc_q + PC_STEP;
          state_d  = FETCH;
        end
      end

      DRAIN: begin
        // An ack in the same cycle as a fresh redirect still retires the old
        // request, so there is nothing left to drain.
        if (redirect) begin
          if (imem_ack) begin
            pc_d    = redirect_tgt;
            state_d = FETCH;
          end else begin
            tgt_d = redirect_tgt;
          end
        end else if (imem_ack) begin
          pc_d    = tgt_q;
          state_d = FETCH;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      pc_out_q <= '0;
      inst_q   <= NOP_INST;
      valid_q  <= 1'b0;
      flush_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      inst_q   <= inst_d;
      valid_q  <= valid_d;
      flush_q  <= flush_d;
    end
  end

  // NOTE: the buffered instruction and drain target are pure data, only read
  // in states that first write them, so they carry no reset.
  always_ff @(posedge clk) begin
    tgt_q <= tgt_d;
    buf_q <= buf_d;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-programmable memory responder and
// a scoreboard of expected {pc, inst} deliveries popped on every valid_o.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        valid_o;
  logic        flush_o;

  fetch_unit #(
    .XLEN    (32),
    .RESET_PC(32'h0000_0000),
    .NOP_INST(NOP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .pc_o       (pc_o),
    .inst_o     (inst_o),
    .valid_o    (valid_o),
    .flush_o    (flush_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  bit   mem_on;
  int   mem_lat;
  int   cnt;
  bit   stray_ack;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = pc ^ KEY;
    sb.push_back(e);
  endtask

  // One clock: sample outputs 1 time unit after the edge, score any delivery,
  // then compute the memory's response for the next edge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'(valid_o), 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_pc_o", pc_o, e.pc);
        check("sb_inst_o", inst_o, e.inst);
      end
    end
    if (imem_req !== 1'b1) begin
      cnt        = 0;
      imem_ack   = stray_ack;
      imem_rdata = stray_ack ? 32'hDEAD_BEEF : 32'h0;
    end else if (mem_on && cnt >= mem_lat) begin
      imem_ack   = 1'b1;
      imem_rdata = imem_addr ^ KEY;
      cnt        = 0;
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
      cnt        = mem_on ? cnt + 1 : 0;
    end
  endtask

  task automatic drain_sb(input string tag, input int limit);
    for (int i = 0; i < limit && sb.size() != 0; i++) tick();
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    mem_on = 1'b1; mem_lat = 0; cnt = 0; stray_ack = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_flush", 32'(flush_o), 32'd0);
    check("rst_pc_o", pc_o, 32'h0);
    check("rst_inst_o", inst_o, NOP);

    // Zero-latency memory: back-to-back deliveries 0,4,8,C
    for (int i = 0; i < 4; i++) push_exp(32'(i * 4));
    rst = 1'b0;
    tick();
    check("t1_req_after_rst", 32'(imem_req), 32'd1);
    check("t1_first_addr", imem_addr, 32'h0);
    check("t1_no_valid_yet", 32'(valid_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_on = 1'b0;
      tick();
      check("t1_valid_b2b", 32'(valid_o), 32'd1);
    end
    check("t1_sb_empty", 32'(sb.size()), 32'd0);
    check("t1_next_addr", imem_addr, 32'h10);

    // Three-cycle ack latency: address held, pc advances only on ack
    mem_on = 1'b1; mem_lat = 3;
    push_exp(32'h10); push_exp(32'h14);
    repeat (4) begin
      tick();
      check("t2_addr_stable", imem_addr, 32'h10);
      check("t2_no_valid", 32'(valid_o), 32'd0);
    end
    tick();
    check("t2_valid", 32'(valid_o), 32'd1);
    check("t2_addr_inc", imem_addr, 32'h14);
    repeat (3) begin
      tick();
      check("t2_addr_stable2", imem_addr, 32'h14);
      check("t2_no_valid2", 32'(valid_o), 32'd0);
    end
    mem_on = 1'b0;
    tick();
    check("t2_valid2", 32'(valid_o), 32'd1);
    check("t2_sb_empty", 32'(sb.size()), 32'd0);

    // Stall coinciding with the ack at 0x8, stray acks while in HOLD
    rst = 1'b1; mem_on = 1'b1; mem_lat = 0;
    repeat (2) tick();
    check("t3_rst_req", 32'(imem_req), 32'd0);
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
    rst = 1'b0;
    repeat (3) tick();
    stall = 1'b1; stray_ack = 1'b1;
    repeat (4) begin
      tick();
      check("t3_stall_no_valid", 32'(valid_o), 32'd0);
      check("t3_hold_req", 32'(imem_req), 32'd0);
    end
    stall = 1'b0; stray_ack = 1'b0; mem_on = 1'b0;
    tick();
    check("t3_release_valid", 32'(valid_o), 32'd1);
    check("t3_next_addr", imem_addr, 32'hC);
    check("t3_req", 32'(imem_req), 32'd1);
    check("t3_sb_empty", 32'(sb.size()), 32'd0);

    // Redirect to 0x103 while the fetch of 0x10 is outstanding
    push_exp(32'hC);
    mem_on = 1'b1;
    tick();
    mem_on = 1'b0;
    tick();
    check("t4_pre_addr", imem_addr, 32'h10);
    mem_on = 1'b1; mem_lat = 2; redirect = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    check("t4_flush", 32'(flush_o), 32'd1);
    check("t4_flush_nop", inst_o, NOP);
    check("t4_flush_novalid", 32'(valid_o), 32'd0);
    check("t4_drain_addr", imem_addr, 32'h10);
    check("t4_drain_req", 32'(imem_req), 32'd1);
    tick();
    check("t4_flush_pulse", 32'(flush_o), 32'd0);
    check("t4_drain_hold", imem_addr, 32'h10);
    tick();
    tick();
    check("t4_redirect_addr", imem_addr, 32'h100);
    check("t4_drop", 32'(valid_o), 32'd0);
    push_exp(32'h100);
    drain_sb("t4_target_delivered", 10);
    mem_on = 1'b0;
    check("t4_after_addr", imem_addr, 32'h104);

    // Redirect together with stall and ack: data dropped, resume at target
    mem_on = 1'b1; mem_lat = 0;
    tick();
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    check("t5_flush", 32'(flush_o), 32'd1);
    check("t5_novalid", 32'(valid_o), 32'd0);
    check("t5_nop", inst_o, NOP);
    check("t5_addr", imem_addr, 32'h200);
    tick();
    check("t5_hold_req", 32'(imem_req), 32'd0);
    check("t5_novalid2", 32'(valid_o), 32'd0);
    check("t5_flush_pulse", 32'(flush_o), 32'd0);
    tick();
    check("t5_hold_req2", 32'(imem_req), 32'd0);
    push_exp(32'h200);
    stall = 1'b0; mem_on = 1'b0;
    tick();
    check("t5_resume_valid", 32'(valid_o), 32'd1);
    check("t5_resume_addr", imem_addr, 32'h204);
    check("t5_sb_empty", 32'(sb.size()), 32'd0);

    // Reset lands on the same edge as the DRAIN's late ack
    mem_on = 1'b1; mem_lat = 2; redirect = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect = 1'b0;
    check("t6_drain_addr", imem_addr, 32'h204);
    tick();
    tick();
    rst = 1'b1; stray_ack = 1'b1;
    tick();
    check("t6_rst_req", 32'(imem_req), 32'd0);
    check("t6_rst_addr", imem_addr, 32'h0);
    check("t6_rst_valid", 32'(valid_o), 32'd0);
    check("t6_rst_pc_o", pc_o, 32'h0);
    check("t6_rst_inst_o", inst_o, NOP);
    tick();
    mem_lat = 0; stray_ack = 1'b0;
    push_exp(32'h0);
    rst = 1'b0;
    tick();
    check("t6_post_rst_valid", 32'(valid_o), 32'd0);
    check("t6_post_rst_req", 32'(imem_req), 32'd1);
    check("t6_post_rst_addr", imem_addr, 32'h0);
    mem_on = 1'b0;
    tick();
    check("t6_first_valid", 32'(valid_o), 32'd1);
    check("t6_sb_empty", 32'(sb.size()), 32'd0);

    // Unaligned redirect to 0xFFFF_FFFE, then PC wraps to zero
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE; mem_on = 1'b1; mem_lat = 0;
    tick();
    redirect = 1'b0;
    check("t7_flush", 32'(flush_o), 32'd1);
    check("t7_drain_addr", imem_addr, 32'h4);
    push_exp(32'hFFFF_FFFC);
    tick();
    check("t7_aligned_addr", imem_addr, 32'hFFFF_FFFC);
    check("t7_drop", 32'(valid_o), 32'd0);
    mem_on = 1'b0;
    tick();
    check("t7_wrap_valid", 32'(valid_o), 32'd1);
    check("t7_wrap_addr", imem_addr, 32'h0);
    check("t7_sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage; the producer side of the IF/ID pipeline register.
- Holds the PC and issues requests to instruction memory with a req/ack handshake of variable latency.
- Delivers {pc, instruction} pairs together with a one-cycle write strobe into the IF/ID register.
- Honours stall requests from hazard logic and branch/jump redirects, which squash in-flight fetches.

Parameters:
- XLEN, 32, datapath and PC width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0013, instruction driven on inst_o when idle or flushed (addi x0,x0,0).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  IF/ID must hold; no new delivery while high
- redirect  in  1  branch taken or jump, one-cycle pulse
- redirect_pc  in  XLEN  new fetch target
- imem_req  out  1  request valid
- imem_addr  out  XLEN  request address (word aligned)
- imem_ack  in  1  memory returns imem_rdata this cycle
- imem_rdata  in  32  fetched instruction
- pc_o  out  XLEN  PC of the delivered instruction (IF/ID D upper half)
- inst_o  out  32  delivered instruction (IF/ID D lower half)
- valid_o  out  1  one-cycle write strobe for IF/ID en
- flush_o  out  1  one-cycle pulse clearing IF/ID on redirect

Behaviour:
- Reset (synchronous; applies at any time, including mid-request):
  - pc = RESET_PC, state = IDLE.
  - imem_req = 0, pc_o = 0, inst_o = NOP_INST, valid_o = 0, flush_o = 0.
  - Any outstanding ack is ignored.
- All outputs are registered. imem_req and imem_addr are derived from state and pc only, so there is no combinational path from any input to them.
- IDLE: entered from reset. Moves to FETCH on the first cycle with rst = 0.
- FETCH:
  - imem_req = 1, imem_addr = pc.
  - imem_ack is sampled at the clock edge while imem_req = 1; the minimum request-to-delivery latency is 1 cycle.
  - On ack with stall = 0: pc_o <= pc, inst_o <= imem_rdata, valid_o <= 1, pc <= pc + 4; remain in FETCH (back-to-back fetches).
  - On ack with stall = 1: buffer imem_rdata and its pc; go to HOLD.
  - No ack: remain in FETCH with req held and address stable.
- HOLD:
  - imem_req = 0.
  - When stall = 0: deliver the buffered pair (valid_o = 1), pc <= buffered pc + 4, go to FETCH.
- DRAIN: entered when a redirect hits FETCH before its ack.
  - imem_req stays 1 with the old address until ack.
  - The acked data is discarded (no valid_o).
  - Then go to FETCH at the redirected pc.
- valid_o is high for exactly one cycle per delivered instruction and is 0 otherwise. pc_o and inst_o hold their last values while valid_o = 0.
- Redirect has the highest priority, over ack and stall:
  - pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - flush_o <= 1 for one cycle, inst_o <= NOP_INST, valid_o <= 0.
  - Any buffered HOLD instruction is dropped.
  - From FETCH with no ack that cycle: go to DRAIN.
  - From FETCH with ack in the same cycle: the data is dropped; go to FETCH at the new pc.
  - From HOLD or IDLE: go to FETCH.
  - A redirect during DRAIN updates the target pc and stays in DRAIN.
- Stall does not block redirect or flush_o.
- PC arithmetic is modulo 2^XLEN: 0xFFFF_FFFC + 4 = 0x0000_0000.
- imem_ack while imem_req = 0 is ignored.

Test Plan:
- Reset, zero-latency memory (ack on every req), imem_rdata = addr ^ 0xA5A5_0000 -> valid_o on consecutive cycles; pc_o = 0, 4, 8, 0xC; inst_o matches; imem_req = 0 during reset.
- Memory acks 3 cycles after req -> imem_addr stable for 3 cycles; one valid_o per ack; pc increments by 4 only on ack.
- stall = 1 for 4 cycles coinciding with an ack at pc = 0x8 -> no valid_o while stalled; imem_req = 0 in HOLD; on stall release, valid_o with pc_o = 0x8 and buffered inst; next imem_addr = 0xC.
- redirect with redirect_pc = 0x0000_0103 while a request to 0x10 is outstanding (ack arrives 2 cycles later) -> flush_o = 1 for one cycle; the 0x10 data is never delivered; next imem_addr = 0x100; next valid_o has pc_o = 0x100.
- redirect in the same cycle as stall = 1 and an ack -> flush_o = 1, valid_o = 0, held data dropped; fetch resumes at the target after stall.
- Reset asserted mid-DRAIN, and a separate fetch from 0xFFFF_FFFC -> after reset, imem_addr = RESET_PC and the late ack is ignored; in the wrap case, the fetch after 0xFFFF_FFFC targets 0x0000_0000.
